// File: rtl/grid_lsq_arbiter_pkg.sv
// Shared types for the grid LSQ arbiter: slot request record, slot id and sizing constants.
package grid_lsq_arbiter_pkg;

    localparam int XLEN           = 32;
    localparam int NUM_GRID_SLOTS = 4;
    localparam int MAX_IDS        = 4;

    typedef logic [$clog2(NUM_GRID_SLOTS)-1:0] slot_id_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [2:0]      fn3;
        logic            load;
        logic            store;
    } lsq_slot_req_t;

    // Only a pure load produces an in-order response; malformed requests never take a tag.
    function automatic logic needs_tag(input lsq_slot_req_t r);
        return r.load & ~r.store;
    endfunction

endpackage

// File: rtl/grid_lsq_req_buffer.sv
// Per-slot request buffer holding lsq_slot_req_t entries.
// Latency: one cycle from push to head_vld.
// Backpressure: full comes from the registered count; a push while full is dropped and flagged.
module grid_lsq_req_buffer
    import grid_lsq_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  lsq_slot_req_t req,
    input  logic          pop,
    output lsq_slot_req_t head,
    output logic          head_vld,
    output logic          full,
    output logic          overflow
);
    assign overflow = push & full;

    taiga_fifo #(
        .DATA_WIDTH ($bits(lsq_slot_req_t)),
        .FIFO_DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .data_in  (req),
        .data_out (head),
        .valid    (head_vld),
        .full     (full)
    );

endmodule

// File: rtl/taiga_fifo.sv
// Generic count-based FIFO, FIFO_DEPTH a power of 2 (>=2).
// Latency: push visible at data_out the cycle after; data_out is the combinational head.
// Backpressure: push while full is ignored; pop while empty is ignored.
module taiga_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  full
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [PW:0]           count;
    logic                  wr_en;
    logic                  rd_en;

    assign wr_en    = push & ~full;
    assign rd_en    = pop & valid;
    assign valid    = (count != '0);
    assign full     = (count == (PW+1)'(FIFO_DEPTH));
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(wr_en) - (PW+1)'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/grid_lsq_arbiter.sv
// Round-robin merge of per-slot LSQ requests onto one core port, routing in-order load data back by tag.
// Latency: buffer->LSQ >=1 cycle, issue combinational from head; LSQ response->slot 1 cycle.
// Backpressure: lsq_full stalls issue; loads also wait on a free tag; slot_lsq_full per slot.
module grid_lsq_arbiter
    import grid_lsq_arbiter_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_GRID_SLOTS,
    parameter int REQ_DEPTH = 2,
    parameter int MAX_LOADS = MAX_IDS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SLOTS*XLEN-1:0] slot_addr,
    input  logic [NUM_SLOTS*XLEN-1:0] slot_data,
    input  logic [NUM_SLOTS*3-1:0]    slot_fn3,
    input  logic [NUM_SLOTS-1:0]      slot_load,
    input  logic [NUM_SLOTS-1:0]      slot_store,
    input  logic [NUM_SLOTS-1:0]      slot_new_request,
    output logic [NUM_SLOTS-1:0]      slot_lsq_full,
    output logic [XLEN-1:0]           slot_rd_data,
    output logic [NUM_SLOTS-1:0]      slot_rd_valid,
    output logic [XLEN-1:0]           lsq_addr,
    output logic [XLEN-1:0]           lsq_data,
    output logic [2:0]                lsq_fn3,
    output logic                      lsq_load,
    output logic                      lsq_store,
    output logic                      lsq_new_request,
    input  logic                      lsq_full,
    input  logic [XLEN-1:0]           lsq_rd_data,
    input  logic                      lsq_rd_valid,
    output logic                      protocol_err
);
    localparam int SW = $clog2(NUM_SLOTS);
    typedef logic [SW-1:0] sid_t;

    lsq_slot_req_t          slot_req [NUM_SLOTS];
    lsq_slot_req_t          head     [NUM_SLOTS];
    lsq_slot_req_t          granted;
    logic [NUM_SLOTS-1:0]   head_vld;
    logic [NUM_SLOTS-1:0]   eligible;
    logic [NUM_SLOTS-1:0]   pop;
    logic [NUM_SLOTS-1:0]   overflow;
    sid_t                   rr_ptr;
    sid_t                   grant_idx;
    logic                   grant_vld;
    logic                   issue;
    int                     idx;
    logic                   tag_vld;
    logic                   tag_full;
    sid_t                   tag_head;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        assign slot_req[i] = '{addr:  slot_addr[i*XLEN +: XLEN],
                               data:  slot_data[i*XLEN +: XLEN],
                               fn3:   slot_fn3[i*3 +: 3],
                               load:  slot_load[i],
                               store: slot_store[i]};

        grid_lsq_req_buffer #(.DEPTH(REQ_DEPTH)) u_buf (
            .clk      (clk),
            .rst      (rst),
            .push     (slot_new_request[i]),
            .req      (slot_req[i]),
            .pop      (pop[i]),
            .head     (head[i]),
            .head_vld (head_vld[i]),
            .full     (slot_lsq_full[i]),
            .overflow (overflow[i])
        );

        // A load whose response cannot be tracked must wait; others may pass it.
        assign eligible[i] = head_vld[i] & (~needs_tag(head[i]) | ~tag_full);
        assign pop[i]      = issue & (grant_idx == sid_t'(i));
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int off = 0; off < NUM_SLOTS; off++) begin
            idx = (int'(rr_ptr) + off) % NUM_SLOTS;
            if (!grant_vld && eligible[idx]) begin
                grant_vld = 1'b1;
                grant_idx = sid_t'(idx);
            end
        end
    end

    assign issue           = grant_vld & ~lsq_full;
    assign granted         = head[grant_idx];
    assign lsq_new_request = issue;
    assign lsq_addr        = issue ? granted.addr  : '0;
    assign lsq_data        = issue ? granted.data  : '0;
    assign lsq_fn3         = issue ? granted.fn3   : '0;
    assign lsq_load        = issue & granted.load;
    assign lsq_store       = issue & granted.store;

    taiga_fifo #(
        .DATA_WIDTH (SW),
        .FIFO_DEPTH (MAX_LOADS)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (issue & needs_tag(granted)),
        .pop      (lsq_rd_valid),
        .data_in  (grant_idx),
        .data_out (tag_head),
        .valid    (tag_vld),
        .full     (tag_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= '0;
            slot_rd_valid <= '0;
            slot_rd_data  <= '0;
            protocol_err  <= 1'b0;
        end else begin
            if (issue)
                rr_ptr <= (grant_idx == sid_t'(NUM_SLOTS-1)) ? '0 : grant_idx + 1'b1;
            slot_rd_valid <= '0;
            if (lsq_rd_valid) begin
                slot_rd_data <= lsq_rd_data;
                if (tag_vld)
                    slot_rd_valid <= {{(NUM_SLOTS-1){1'b0}}, 1'b1} << tag_head;
            end
            if ((|overflow) || (lsq_rd_valid && !tag_vld))
                protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_grid_lsq_arbiter.sv
// Directed bench for grid_lsq_arbiter with request/response scoreboards checked every cycle.
module tb_grid_lsq_arbiter;
    import grid_lsq_arbiter_pkg::*;

    localparam int NS = 4;

    logic               clk;
    logic               rst;
    logic [NS*XLEN-1:0] slot_addr;
    logic [NS*XLEN-1:0] slot_data;
    logic [NS*3-1:0]    slot_fn3;
    logic [NS-1:0]      slot_load;
    logic [NS-1:0]      slot_store;
    logic [NS-1:0]      slot_new_request;
    logic [NS-1:0]      slot_lsq_full;
    logic [XLEN-1:0]    slot_rd_data;
    logic [NS-1:0]      slot_rd_valid;
    logic [XLEN-1:0]    lsq_addr;
    logic [XLEN-1:0]    lsq_data;
    logic [2:0]         lsq_fn3;
    logic               lsq_load;
    logic               lsq_store;
    logic               lsq_new_request;
    logic               lsq_full;
    logic [XLEN-1:0]    lsq_rd_data;
    logic               lsq_rd_valid;
    logic               protocol_err;

    int checks = 0;
    int errors = 0;

    logic [68:0] exp_req [$];
    logic [35:0] exp_rsp [$];

    grid_lsq_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .slot_addr        (slot_addr),
        .slot_data        (slot_data),
        .slot_fn3         (slot_fn3),
        .slot_load        (slot_load),
        .slot_store       (slot_store),
        .slot_new_request (slot_new_request),
        .slot_lsq_full    (slot_lsq_full),
        .slot_rd_data     (slot_rd_data),
        .slot_rd_valid    (slot_rd_valid),
        .lsq_addr         (lsq_addr),
        .lsq_data         (lsq_data),
        .lsq_fn3          (lsq_fn3),
        .lsq_load         (lsq_load),
        .lsq_store        (lsq_store),
        .lsq_new_request  (lsq_new_request),
        .lsq_full         (lsq_full),
        .lsq_rd_data      (lsq_rd_data),
        .lsq_rd_valid     (lsq_rd_valid),
        .protocol_err     (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Sample at the falling edge against the scoreboards, then advance past the next rising edge.
    task automatic tick();
        logic [68:0] rq;
        logic [35:0] rs;
        @(negedge clk);
        if (lsq_new_request === 1'b1) begin
            if (exp_req.size() == 0) begin
                chk("unexpected_req", 80'(lsq_addr), 80'(0));
            end else begin
                rq = exp_req.pop_front();
                chk("lsq_req", 80'({lsq_addr, lsq_data, lsq_fn3, lsq_load, lsq_store}), 80'(rq));
            end
        end
        if (slot_rd_valid !== '0) begin
            if (exp_rsp.size() == 0) begin
                chk("unexpected_rsp", 80'(slot_rd_valid), 80'(0));
            end else begin
                rs = exp_rsp.pop_front();
                chk("slot_rsp", 80'({slot_rd_valid, slot_rd_data}), 80'(rs));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int s, input logic [31:0] a, input logic [2:0] f,
                           input logic ld, input logic st, input bit expect_issue);
        slot_addr[s*XLEN +: XLEN] = a;
        slot_data[s*XLEN +: XLEN] = ~a;
        slot_fn3[s*3 +: 3]        = f;
        slot_load[s]              = ld;
        slot_store[s]             = st;
        slot_new_request[s]       = 1'b1;
        if (expect_issue) exp_req.push_back({a, ~a, f, ld, st});
    endtask

    task automatic clear_req();
        slot_new_request = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain_chk(input string tag);
        chk({tag, "_req_left"}, 80'(exp_req.size()), 80'(0));
        chk({tag, "_rsp_left"}, 80'(exp_rsp.size()), 80'(0));
    endtask

    initial begin
        rst = 1'b1;
        slot_addr = '0; slot_data = '0; slot_fn3 = '0;
        slot_load = '0; slot_store = '0; slot_new_request = '0;
        lsq_full = 1'b0; lsq_rd_data = '0; lsq_rd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_lsq_req", 80'(lsq_new_request), 80'(0));
        chk("rst_lsq_addr", 80'(lsq_addr), 80'(0));
        chk("rst_slot_full", 80'(slot_lsq_full), 80'(0));
        chk("rst_rd_valid", 80'(slot_rd_valid), 80'(0));
        chk("rst_rd_data", 80'(slot_rd_data), 80'(0));
        chk("rst_perr", 80'(protocol_err), 80'(0));

        // Single load from slot 2 and its response.
        set_req(2, 32'h100, 3'b010, 1'b1, 1'b0, 1'b1);
        tick();
        clear_req();
        tick();
        lsq_rd_valid = 1'b1; lsq_rd_data = 32'hDEADBEEF;
        exp_rsp.push_back({4'b0100, 32'hDEADBEEF});
        tick();
        lsq_rd_valid = 1'b0;
        tick();
        drain_chk("t1");

        // Four simultaneous stores, then a fairness pair.
        do_reset();
        for (int s = 0; s < NS; s++) set_req(s, 32'h200 + 32'(s * 4), 3'b010, 1'b0, 1'b1, 1'b1);
        tick();
        clear_req();
        repeat (4) tick();
        chk("t2_order_done", 80'(exp_req.size()), 80'(0));
        set_req(1, 32'h244, 3'b001, 1'b0, 1'b1, 1'b1);
        set_req(3, 32'h24C, 3'b000, 1'b0, 1'b1, 1'b1);
        tick();
        clear_req();
        repeat (3) tick();
        drain_chk("t2");
        chk("t2_perr", 80'(protocol_err), 80'(0));

        // Overflow while the LSQ is full.
        lsq_full = 1'b1;
        set_req(0, 32'h300, 3'b010, 1'b0, 1'b1, 1'b1);
        tick();
        chk("t3_full_after1", 80'(slot_lsq_full[0]), 80'(0));
        set_req(0, 32'h304, 3'b010, 1'b0, 1'b1, 1'b1);
        tick();
        chk("t3_full_after2", 80'(slot_lsq_full[0]), 80'(1));
        set_req(0, 32'h308, 3'b010, 1'b0, 1'b1, 1'b0);
        tick();
        clear_req();
        chk("t3_perr", 80'(protocol_err), 80'(1));
        repeat (2) tick();
        lsq_full = 1'b0;
        repeat (3) tick();
        chk("t3_full_released", 80'(slot_lsq_full[0]), 80'(0));
        drain_chk("t3");

        // Tag FIFO full: store passes, load waits for the first response.
        do_reset();
        chk("t4_perr_cleared", 80'(protocol_err), 80'(0));
        for (int j = 0; j < MAX_IDS; j++) begin
            set_req(0, 32'h400 + 32'(j * 4), 3'b010, 1'b1, 1'b0, 1'b1);
            tick();
        end
        clear_req();
        tick();
        set_req(2, 32'h420, 3'b010, 1'b0, 1'b1, 1'b1);
        set_req(1, 32'h410, 3'b100, 1'b1, 1'b0, 1'b1);
        tick();
        clear_req();
        tick();
        repeat (2) tick();
        chk("t4_load_held", 80'(exp_req.size()), 80'(1));
        for (int j = 0; j <= MAX_IDS; j++) begin
            lsq_rd_valid = 1'b1;
            lsq_rd_data  = 32'hA000_0000 + 32'(j);
            exp_rsp.push_back({(j < MAX_IDS) ? 4'b0001 : 4'b0010, 32'hA000_0000 + 32'(j)});
            tick();
        end
        lsq_rd_valid = 1'b0;
        repeat (2) tick();
        drain_chk("t4");

        // Response with no outstanding tag.
        do_reset();
        lsq_rd_valid = 1'b1; lsq_rd_data = 32'h5555;
        tick();
        lsq_rd_valid = 1'b0;
        chk("t5_perr", 80'(protocol_err), 80'(1));
        chk("t5_no_valid", 80'(slot_rd_valid), 80'(0));
        repeat (3) tick();
        chk("t5_perr_sticky", 80'(protocol_err), 80'(1));
        do_reset();
        chk("t5_perr_rst", 80'(protocol_err), 80'(0));

        // Reset with queued requests and outstanding tags.
        set_req(0, 32'h600, 3'b010, 1'b1, 1'b0, 1'b1);
        tick();
        set_req(0, 32'h604, 3'b010, 1'b1, 1'b0, 1'b1);
        tick();
        clear_req();
        tick();
        lsq_full = 1'b1;
        for (int s = 1; s < NS; s++) set_req(s, 32'h700 + 32'(s * 4), 3'b010, 1'b0, 1'b1, 1'b0);
        tick();
        clear_req();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lsq_full = 1'b0;
        chk("t6_lsq_req", 80'(lsq_new_request), 80'(0));
        chk("t6_lsq_addr", 80'(lsq_addr), 80'(0));
        chk("t6_slot_full", 80'(slot_lsq_full), 80'(0));
        chk("t6_rd_valid", 80'(slot_rd_valid), 80'(0));
        chk("t6_perr", 80'(protocol_err), 80'(0));
        lsq_rd_valid = 1'b1; lsq_rd_data = 32'h6666;
        tick();
        lsq_rd_valid = 1'b0;
        chk("t6_post_perr", 80'(protocol_err), 80'(1));
        chk("t6_post_no_valid", 80'(slot_rd_valid), 80'(0));
        repeat (3) tick();
        drain_chk("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
